// File: rtl/ctrl_microsequencer_if.sv
// Handshake/bus bundle between a tile controller and ctrl_microsequencer.
// step_req exists only when CTRL_MICROSEQUENCER_SINGLE_STEP_EN is defined.
interface ctrl_microsequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 16,
    parameter int STEPS    = 6
);
    localparam int STEP_W = $clog2(STEPS);
    localparam int ADDR_W = OPCODE_W + STEP_W;

    logic                ena;
    logic                start;
    logic [OPCODE_W-1:0] opcode;
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [CTRL_W-1:0]   prog_data;
    logic [CTRL_W-1:0]   ctrl_out;
    logic [STEP_W-1:0]   step;
    logic                busy;
    logic                halted;
`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
    logic                step_req;
`endif

    modport master (
        output ena, start, opcode, prog_we, prog_addr, prog_data,
`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
        output step_req,
`endif
        input  ctrl_out, step, busy, halted
    );

    modport slave (
        input  ena, start, opcode, prog_we, prog_addr, prog_data,
`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
        input  step_req,
`endif
        output ctrl_out, step, busy, halted
    );
endinterface

// File: rtl/ctrl_microsequencer.sv
// Microcoded control unit: writable {opcode, step} microcode RAM walked by a T-state counter.
// Optional feature macro: CTRL_MICROSEQUENCER_SINGLE_STEP_EN (adds step_req debug stepping).
module ctrl_microsequencer #(
    parameter int OPCODE_W = 4,
    parameter int CTRL_W   = 16,
    parameter int STEPS    = 6,
    parameter int HALT_BIT = 15,
    parameter int END_BIT  = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ctrl_microsequencer_if.slave   bus
);
    localparam int STEP_W = $clog2(STEPS);
    localparam int ADDR_W = OPCODE_W + STEP_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [STEP_W-1:0]     r_step,  w_step_next;
    logic [OPCODE_W-1:0]   r_op,    w_op_next;
    logic [CTRL_W-1:0]     r_ctrl,  w_ctrl_next;
    logic [CTRL_W-1:0]     r_ucode [DEPTH];

    logic [ADDR_W-1:0]     w_rd_addr;
    logic [CTRL_W-1:0]     w_word;
    logic                  w_we;
    logic                  w_run_adv;

    assign w_rd_addr = {r_op, r_step};
    assign w_word    = r_ucode[w_rd_addr];
    assign w_we      = bus.ena && bus.prog_we && (r_state != S_RUN);
`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
    assign w_run_adv = bus.ena && bus.step_req;
`else
    assign w_run_adv = bus.ena;
`endif

    // Microcode store is deliberately left out of reset so programmed code survives rst_n.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ucode[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_op    <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
            r_op    <= w_op_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_op_next    = r_op;
        w_ctrl_next  = r_ctrl;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.ena) begin
                    // Clearing here also retires the halting word one cycle after it showed.
                    w_ctrl_next = '0;
                    if (bus.start) begin
                        w_state_next = S_RUN;
                        w_step_next  = '0;
                        w_op_next    = bus.opcode;
                    end
                end
            end
            S_RUN: begin
                if (w_run_adv) begin
                    w_ctrl_next = w_word;
                    if (w_word[HALT_BIT]) begin
                        w_state_next = S_HALT;
                        w_step_next  = '0;
                    end else if (w_word[END_BIT] || (r_step == STEP_LAST)) begin
                        w_step_next = '0;
                        w_op_next   = bus.opcode;
                    end else begin
                        w_step_next = r_step + STEP_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_ctrl_next  = '0;
            end
        endcase
    end

    assign bus.ctrl_out = r_ctrl;
    assign bus.step     = r_step;
    assign bus.busy     = (r_state == S_RUN);
    assign bus.halted   = (r_state == S_HALT);
endmodule

// File: tb/tb_ctrl_microsequencer.sv
// Directed bench for ctrl_microsequencer with a rule-level reference model checked every cycle.
module tb_ctrl_microsequencer;
    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 16;
    localparam int STEPS    = 6;
    localparam int STEP_W   = $clog2(STEPS);
    localparam int ADDR_W   = OPCODE_W + STEP_W;
    localparam int ROW      = 1 << STEP_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ctrl_microsequencer_if #(.OPCODE_W(OPCODE_W), .CTRL_W(CTRL_W), .STEPS(STEPS)) bus ();

    ctrl_microsequencer #(
        .OPCODE_W(OPCODE_W), .CTRL_W(CTRL_W), .STEPS(STEPS), .HALT_BIT(15), .END_BIT(14)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: modes and integer step/op counters following the sequencing rules.
    typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
    mmode_t            m_mode = M_IDLE;
    int                m_step = 0;
    int                m_op   = 0;
    logic [CTRL_W-1:0] m_ctrl = '0;
    logic [CTRL_W-1:0] m_ram [ROW << OPCODE_W];

    function automatic logic [CTRL_W-1:0] m_read(input int op, input int st);
        return m_ram[op * ROW + st];
    endfunction

    function automatic logic m_adv();
`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
        return bus.ena && bus.step_req;
`else
        return bus.ena;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_step <= 0;
            m_op   <= 0;
            m_ctrl <= '0;
        end else if (m_mode != M_RUN) begin
            if (bus.ena) begin
                if (bus.prog_we) m_ram[bus.prog_addr] <= bus.prog_data;
                m_ctrl <= '0;
                if (bus.start) begin
                    m_mode <= M_RUN;
                    m_step <= 0;
                    m_op   <= int'(bus.opcode);
                end
            end
        end else if (m_adv()) begin
            m_ctrl <= m_read(m_op, m_step);
            if (m_read(m_op, m_step)[15]) begin
                m_mode <= M_HALT;
                m_step <= 0;
            end else if (m_read(m_op, m_step)[14] || m_step == STEPS - 1) begin
                m_step <= 0;
                m_op   <= int'(bus.opcode);
            end else begin
                m_step <= m_step + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ctrl_out", 32'(bus.ctrl_out), 32'(m_ctrl));
        check("step",     32'(bus.step),     m_step);
        check("busy",     32'(bus.busy),     32'(m_mode == M_RUN));
        check("halted",   32'(bus.halted),   32'(m_mode == M_HALT));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic prog(input int op, input int st, input logic [CTRL_W-1:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = ADDR_W'(op * ROW + st);
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    initial begin
        bus.ena = 1'b0; bus.start = 1'b0; bus.opcode = '0;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
        bus.step_req = 1'b1;
`endif
        #1 rst_n = 1'b0;
        #2;
        check("rst_ctrl",   32'(bus.ctrl_out), 32'h0);
        check("rst_step",   32'(bus.step),     32'h0);
        check("rst_busy",   32'(bus.busy),     32'h0);
        check("rst_halted", 32'(bus.halted),   32'h0);
        tick(); tick();
        rst_n = 1'b1; bus.ena = 1'b1;
        repeat (3) tick();
        check("idle_no_start_busy", 32'(bus.busy), 32'h0);

        for (int s = 0; s < 6; s++) prog(3, s, CTRL_W'(1 << s));
        prog(5, 0, 16'h0100); prog(5, 1, 16'h0200); prog(5, 2, 16'h4004);
        prog(15, 0, 16'h0040); prog(15, 1, 16'h8000);

        // Op 3 walks all six steps then wraps and re-latches
        bus.opcode = 4'd3; bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_busy", 32'(bus.busy), 32'h1);
        check("start_ctrl", 32'(bus.ctrl_out), 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick(); check("op3_word", 32'(bus.ctrl_out), 32'(1 << i));
        end
        tick();
        check("op3_wrap", 32'(bus.ctrl_out), 32'h0001);
        check("op3_wrap_step", 32'(bus.step), 32'h1);
        bus.opcode = 4'd5;
        for (int i = 1; i < 6; i++) begin
            tick(); check("op3_tail", 32'(bus.ctrl_out), 32'(1 << i));
        end
        // Op 5 ends early on the END bit
        tick(); check("op5_w0", 32'(bus.ctrl_out), 32'h0100);
        bus.opcode = 4'hF;
        tick(); check("op5_w1", 32'(bus.ctrl_out), 32'h0200);
        tick(); check("op5_end", 32'(bus.ctrl_out), 32'h4004);
        check("op5_end_step", 32'(bus.step), 32'h0);
        // Op F halts on step 1
        tick(); check("opF_w0", 32'(bus.ctrl_out), 32'h0040);
        tick(); check("halt_word", 32'(bus.ctrl_out), 32'h8000);
        check("halt_flag", 32'(bus.halted), 32'h1);
        tick(); check("halt_clear", 32'(bus.ctrl_out), 32'h0000);
        check("halt_hold", 32'(bus.halted), 32'h1);
        bus.opcode = 4'd3; bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("resume_busy", 32'(bus.busy), 32'h1);
        tick(); check("resume_word", 32'(bus.ctrl_out), 32'h0001);

        // Write while running is dropped
        bus.prog_we = 1'b1; bus.prog_addr = ADDR_W'(3 * ROW); bus.prog_data = 16'hFFFF;
        tick(); bus.prog_we = 1'b0;
        check("run_write_word", 32'(bus.ctrl_out), 32'h0002);
        repeat (4) tick();
        tick(); check("run_write_ignored", 32'(bus.ctrl_out), 32'h0001);
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_ctrl", 32'(bus.ctrl_out), 32'h0001);
            check("freeze_step", 32'(bus.step), 32'h1);
        end
        bus.ena = 1'b1;
        tick(); check("unfreeze", 32'(bus.ctrl_out), 32'h0002);
        tick(); tick();
        check("pre_reset_step", 32'(bus.step), 32'h4);

        // Asynchronous reset mid-instruction
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", 32'(bus.ctrl_out), 32'h0);
        check("async_rst_busy", 32'(bus.busy), 32'h0);
        check("async_rst_step", 32'(bus.step), 32'h0);
        tick(); rst_n = 1'b1;

        // Write together with start: first read sees the new word
        bus.opcode = 4'd3; bus.start = 1'b1;
        bus.prog_we = 1'b1; bus.prog_addr = ADDR_W'(3 * ROW); bus.prog_data = 16'h0A0A;
        tick(); bus.start = 1'b0; bus.prog_we = 1'b0;
        check("we_start_busy", 32'(bus.busy), 32'h1);
        tick(); check("we_start_word", 32'(bus.ctrl_out), 32'h0A0A);

`ifdef CTRL_MICROSEQUENCER_SINGLE_STEP_EN
        bus.step_req = 1'b0;
        repeat (2) tick();
        check("ss_hold_ctrl", 32'(bus.ctrl_out), 32'h0A0A);
        check("ss_hold_step", 32'(bus.step), 32'h1);
        bus.step_req = 1'b1; tick(); bus.step_req = 1'b0;
        check("ss_pulse", 32'(bus.ctrl_out), 32'h0002);
        tick(); check("ss_after_pulse", 32'(bus.ctrl_out), 32'h0002);
        bus.step_req = 1'b1;
`endif
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
